// File: rtl/s2_packer_pkg.sv
// s2_packer_pkg: shared types and constants for the s2 byte packer.
//   LANES/LANE_W : bytes per 64-bit s2 word and lane-index width
//   S2_ADDR_W    : s2 word-address width carried in a write request
//   state_e      : packer FSM states
//   wr_req_t     : one s2 write request {addr, data, be}
package s2_packer_pkg;

    localparam int LANES     = 8;
    localparam int LANE_W    = 3;
    localparam int S2_ADDR_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        DONE
    } state_e;

    typedef struct packed {
        logic [S2_ADDR_W-1:0] addr;
        logic [LANES*8-1:0]   data;
        logic [LANES-1:0]     be;
    } wr_req_t;

endpackage

// File: rtl/s2_byte_packer_if.sv
// s2_byte_packer_if: byte stream in + Avalon-MM s2 write port out.
//   in_data/in_valid/in_last/in_ready : 8-bit valid/ready byte stream
//   onchip_memory2_0_s2_*             : 64-bit s2 write port (no waitrequest)
//   master : packer side, slave : stream source / memory side
interface s2_byte_packer_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] onchip_memory2_0_s2_address;
    logic              onchip_memory2_0_s2_chipselect;
    logic              onchip_memory2_0_s2_clken;
    logic              onchip_memory2_0_s2_write;
    logic [63:0]       onchip_memory2_0_s2_writedata;
    logic [7:0]        onchip_memory2_0_s2_byteenable;

    modport master (
        input  in_data, in_valid, in_last,
        output in_ready,
        output onchip_memory2_0_s2_address, onchip_memory2_0_s2_chipselect,
               onchip_memory2_0_s2_clken, onchip_memory2_0_s2_write,
               onchip_memory2_0_s2_writedata, onchip_memory2_0_s2_byteenable
    );

    modport slave (
        output in_data, in_valid, in_last,
        input  in_ready,
        input  onchip_memory2_0_s2_address, onchip_memory2_0_s2_chipselect,
               onchip_memory2_0_s2_clken, onchip_memory2_0_s2_write,
               onchip_memory2_0_s2_writedata, onchip_memory2_0_s2_byteenable
    );
endinterface

// File: rtl/s2_word_accum.sv
// s2_word_accum: byte-lane accumulator for one 64-bit word.
//   clk/rst_n : clock, async active-low reset
//   clr       : start of frame, resets lane and be_acc
//   push/last/din : accepted byte, final-byte flag, byte value
//   word/be   : accumulated word and lane enables including the byte being pushed
//   complete  : this push finishes a word (lane 7 or last byte)
module s2_word_accum
    import s2_packer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic               last,
    input  logic [7:0]         din,
    output logic [LANES*8-1:0] word,
    output logic [LANES-1:0]   be,
    output logic               complete
);
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [LANES-1:0]   be_q, be_d;
    logic [LANES*8-1:0] data_q, data_d;

    // word/be include the byte in flight so the top can capture in the same cycle
    always_comb begin
        data_d = data_q;
        if (push) data_d[8*lane_q +: 8] = din;
        word     = data_d;
        be       = push ? be_q | (LANES'(1) << lane_q) : be_q;
        complete = push && (last || &lane_q);
        lane_d   = clr ? '0 : lane_q + LANE_W'(push);
        be_d     = (clr || complete) ? '0 : be;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            be_q   <= '0;
            data_q <= '0;
        end else begin
            lane_q <= lane_d;
            be_q   <= be_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/s2_byte_packer.sv
// s2_byte_packer: packs an 8-bit byte stream little-endian into 64-bit s2 writes.
//   clk_clk/reset_reset_n : clock, async active-low reset
//   start/base_addr       : arm a frame at word address base_addr (IDLE only)
//   busy/done             : frame in progress / one-cycle end-of-frame pulse
//   wrapped/byte_count    : frame crossed the top of memory / bytes accepted
//   bus                   : byte stream in, s2 write port out
// Build option S2_PACKER_ZERO_FILL_EN: a partial final word is written with
// all lanes enabled and unused lanes zero instead of be_acc-only lanes.
module s2_byte_packer #(
    parameter int ADDR_W = 14,
    parameter int LANES  = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W+3:0] byte_count,
    s2_byte_packer_if.master  bus
);
    import s2_packer_pkg::*;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    wr_req_t            wr_q, wr_d;
    logic               write_q, write_d;
    logic               more_q, more_d;
    logic               wrapped_q, wrapped_d;
    logic [ADDR_W+3:0]  count_q, count_d;
    logic               go, push, complete;
    logic [LANES*8-1:0] acc_word;
    logic [LANES-1:0]   acc_be;

    assign go   = start && state_q == IDLE;
    assign push = bus.in_valid && state_q == FILL;

    s2_word_accum u_accum (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .clr      (go),
        .push     (push),
        .last     (bus.in_last),
        .din      (bus.in_data),
        .word     (acc_word),
        .be       (acc_be),
        .complete (complete)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (complete && bus.in_last) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            default: state_d = IDLE;
        endcase
        // addr advances as the word is captured, so it already points past it during the write
        addr_d  = go ? base_addr : complete ? addr_q + 1'b1 : addr_q;
        write_d = complete;
        more_d  = complete ? !bus.in_last : more_q;
        wr_d    = wr_q;
        if (complete) begin
            wr_d.addr = addr_q;
`ifdef S2_PACKER_ZERO_FILL_EN
            for (int i = 0; i < LANES; i++) wr_d.data[8*i +: 8] = acc_be[i] ? acc_word[8*i +: 8] : 8'h00;
            wr_d.be = '1;
`else
            wr_d.data = acc_word;
            wr_d.be   = acc_be;
`endif
        end
        // only a write at the top address that is followed by more bytes counts as a wrap
        wrapped_d = go ? 1'b0 : wrapped_q | (write_q & more_q & (&wr_q.addr));
        count_d   = go ? '0 : count_q + (ADDR_W+4)'(push);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_q      <= '0;
            write_q   <= 1'b0;
            more_q    <= 1'b0;
            wrapped_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            write_q   <= write_d;
            more_q    <= more_d;
            wrapped_q <= wrapped_d;
            count_q   <= count_d;
        end
    end

    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign wrapped    = wrapped_q;
    assign byte_count = count_q;

    assign bus.in_ready                       = state_q == FILL;
    assign bus.onchip_memory2_0_s2_address    = wr_q.addr;
    assign bus.onchip_memory2_0_s2_writedata  = wr_q.data;
    assign bus.onchip_memory2_0_s2_byteenable = wr_q.be;
    assign bus.onchip_memory2_0_s2_write      = write_q;
    assign bus.onchip_memory2_0_s2_chipselect = write_q;
    assign bus.onchip_memory2_0_s2_clken      = 1'b1;
endmodule

// File: tb/tb_s2_byte_packer.sv
// tb_s2_byte_packer: randomized self-checking bench against a byte-addressed memory model.
module tb_s2_byte_packer;
    localparam int AW   = 14;
    localparam int MEMB = 1 << (AW + 3);

    logic          clk = 0, rst_n = 0, start = 0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, wrapped;
    logic [AW+3:0] byte_count;

    s2_byte_packer_if #(.ADDR_W(AW)) bus ();

    s2_byte_packer #(.ADDR_W(AW), .LANES(8)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .wrapped       (wrapped),
        .byte_count    (byte_count),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [63:0]   d;
        logic [7:0]    be;
        logic          wr;
    } wrec_t;

    wrec_t      wq[$];
    logic [7:0] mem[int];
    logic [7:0] saved[int];
    logic [7:0] fb[$];
    int         acc[$];
    int         cyc = 0, done_cyc = -1;
    int         n_cmp = 0, n_bad = 0;
    int         ready_bad, busy_after;

    always @(posedge clk) cyc <= cyc + 1;

    // observed memory image; a fresh frame start clears the per-frame record
    always @(negedge clk) begin
        if (start && !busy) begin
            wq.delete();
            mem.delete();
            done_cyc = -1;
        end
        if (bus.onchip_memory2_0_s2_write) begin
            wq.push_back('{cyc, bus.onchip_memory2_0_s2_address, bus.onchip_memory2_0_s2_writedata,
                           bus.onchip_memory2_0_s2_byteenable, wrapped});
            for (int i = 0; i < 8; i++)
                if (bus.onchip_memory2_0_s2_byteenable[i])
                    mem[{bus.onchip_memory2_0_s2_address, 3'(i)}] = bus.onchip_memory2_0_s2_writedata[8*i +: 8];
        end
        if (done) done_cyc = cyc;
    end

    // byte k of the frame lives at byte address base*8+k modulo memory size
    function automatic int mem_diff(input logic [AW-1:0] base);
        int bad = 0;
        int n   = fb.size();
        int b   = int'(base) * 8;
        for (int k = 0; k < n; k++)
            if (!mem.exists((b + k) % MEMB) || mem[(b + k) % MEMB] !== fb[k]) bad++;
        for (int k = n; k < ((n + 7) / 8) * 8; k++) begin
`ifdef S2_PACKER_ZERO_FILL_EN
            if (!mem.exists((b + k) % MEMB) || mem[(b + k) % MEMB] !== 8'h00) bad++;
`else
            if (mem.exists((b + k) % MEMB)) bad++;
`endif
        end
        return bad;
    endfunction

    task automatic fill_random(input int n);
        fb.delete();
        for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input bit throttle, input int inject_at, input int rst_at);
        int k = 0, t = 0;
        bit tog = 1;
        acc.delete();
        ready_bad  = 0;
        busy_after = -1;
        start      = 1;
        base_addr  = base;
        @(posedge clk); #1;
        start = 0;
        while (k < fb.size() && t < 500) begin
            if (k == rst_at) begin
                rst_n        = 0;
                bus.in_valid = 0;
                bus.in_last  = 0;
                return;
            end
            bus.in_valid = throttle ? tog : 1'b1;
            tog          = !tog;
            bus.in_data  = fb[k];
            bus.in_last  = (k == fb.size() - 1);
            if (k == inject_at) begin
                start     = 1;
                base_addr = base ^ 14'h155;
                inject_at = -1;
            end
            @(negedge clk);
            if (!bus.in_ready) ready_bad++;
            if (bus.in_valid && bus.in_ready) begin
                acc.push_back(cyc);
                k++;
            end
            @(posedge clk); #1;
            start = 0;
            t++;
        end
        bus.in_valid = 0;
        bus.in_last  = 0;
        if (k < fb.size()) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_accept: accepted %0d bytes, required %0d", k, fb.size());
            return;
        end
        t = 0;
        while (done_cyc < 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        busy_after = busy;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        bus.in_valid = 0; bus.in_last = 0; bus.in_data = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.in_ready, busy, done, wrapped, byte_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %0h required 0", {bus.in_ready, busy, done, wrapped, byte_count});
        end
        n_cmp++;
        if ({bus.onchip_memory2_0_s2_write, bus.onchip_memory2_0_s2_chipselect, bus.onchip_memory2_0_s2_address,
             bus.onchip_memory2_0_s2_writedata, bus.onchip_memory2_0_s2_byteenable} !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: got %0h required 0", {bus.onchip_memory2_0_s2_write, bus.onchip_memory2_0_s2_address,
                     bus.onchip_memory2_0_s2_writedata, bus.onchip_memory2_0_s2_byteenable});
        end
        n_cmp++;
        if (bus.onchip_memory2_0_s2_clken !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_clken: got %b required 1", bus.onchip_memory2_0_s2_clken);
        end
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, bus.in_ready, bus.onchip_memory2_0_s2_write} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b required 000", {busy, bus.in_ready, bus.onchip_memory2_0_s2_write});
        end
    endtask

    task automatic test_full_words;
        fb.delete();
        for (int k = 0; k < 16; k++) fb.push_back(8'(k));
        run_frame(14'h0010, 0, -1, -1);
        n_cmp++;
        if (wq.size() !== 2) begin
            n_bad++;
            $display("FAIL full_count: got %0d writes required 2", wq.size());
        end else begin
            n_cmp++;
            if ({wq[0].a, wq[0].d, wq[0].be} !== {14'h0010, 64'h0706050403020100, 8'hFF}) begin
                n_bad++;
                $display("FAIL full_w0: got %h %h %h required 0010 0706050403020100 ff", wq[0].a, wq[0].d, wq[0].be);
            end
            n_cmp++;
            if ({wq[1].a, wq[1].d, wq[1].be} !== {14'h0011, 64'h0F0E0D0C0B0A0908, 8'hFF}) begin
                n_bad++;
                $display("FAIL full_w1: got %h %h %h required 0011 0f0e0d0c0b0a0908 ff", wq[1].a, wq[1].d, wq[1].be);
            end
            n_cmp++;
            if (wq[0].cyc !== acc[7] + 1 || wq[1].cyc !== acc[15] + 1) begin
                n_bad++;
                $display("FAIL full_latency: got %0d,%0d required %0d,%0d", wq[0].cyc, wq[1].cyc, acc[7] + 1, acc[15] + 1);
            end
        end
        n_cmp++;
        if (done_cyc !== acc[15] + 2) begin
            n_bad++;
            $display("FAIL full_done: got cycle %0d required %0d", done_cyc, acc[15] + 2);
        end
        n_cmp++;
        if (busy_after !== 0) begin
            n_bad++;
            $display("FAIL full_busy_end: got %0d required 0", busy_after);
        end
        n_cmp++;
        if ({byte_count, wrapped} !== {18'd16, 1'b0}) begin
            n_bad++;
            $display("FAIL full_status: got count %0d wrapped %b required 16 0", byte_count, wrapped);
        end
    endtask

    task automatic test_partial;
        fb.delete();
        fb.push_back(8'hAA); fb.push_back(8'hBB); fb.push_back(8'hCC);
        run_frame(14'h0100, 0, -1, -1);
        n_cmp++;
        if (wq.size() !== 1 || wq[0].a !== 14'h0100) begin
            n_bad++;
            $display("FAIL partial_write: got %0d writes addr %h required 1 at 0100", wq.size(), wq.size() ? wq[0].a : '0);
        end else begin
            n_cmp++;
`ifdef S2_PACKER_ZERO_FILL_EN
            if ({wq[0].be, wq[0].d} !== {8'hFF, 64'h0000000000CCBBAA}) begin
                n_bad++;
                $display("FAIL partial_word: got be %h data %h required ff 0000000000ccbbaa", wq[0].be, wq[0].d);
            end
`else
            if ({wq[0].be, wq[0].d[23:0]} !== {8'h07, 24'hCCBBAA}) begin
                n_bad++;
                $display("FAIL partial_word: got be %h data %h required 07 ccbbaa", wq[0].be, wq[0].d[23:0]);
            end
`endif
        end
        n_cmp++;
        if (mem_diff(14'h0100) !== 0 || byte_count !== 18'd3) begin
            n_bad++;
            $display("FAIL partial_mem: got %0d bad bytes count %0d required 0 and 3", mem_diff(14'h0100), byte_count);
        end
    endtask

    task automatic test_wrap;
        fill_random(16);
        run_frame(14'h3FFF, 0, -1, -1);
        n_cmp++;
        if (wq.size() !== 2) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d writes required 2", wq.size());
        end else begin
            n_cmp++;
            if ({wq[0].a, wq[1].a} !== {14'h3FFF, 14'h0000}) begin
                n_bad++;
                $display("FAIL wrap_addr: got %h,%h required 3fff,0000", wq[0].a, wq[1].a);
            end
            n_cmp++;
            if ({wq[0].wr, wq[1].wr} !== 2'b01) begin
                n_bad++;
                $display("FAIL wrap_timing: wrapped at writes got %b%b required 01", wq[0].wr, wq[1].wr);
            end
        end
        n_cmp++;
        if (wrapped !== 1'b1 || mem_diff(14'h3FFF) !== 0) begin
            n_bad++;
            $display("FAIL wrap_end: got wrapped %b bad bytes %0d required 1 0", wrapped, mem_diff(14'h3FFF));
        end
    endtask

    task automatic test_throttle;
        logic [AW-1:0] base = 14'($urandom);
        int bad = 0;
        fill_random(21);
        run_frame(base, 0, -1, -1);
        saved = mem;
        run_frame(base, 1, -1, -1);
        if (saved.size() != mem.size()) bad++;
        foreach (saved[a]) if (!mem.exists(a) || mem[a] !== saved[a]) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL throttle_same: got %0d differing bytes required 0", bad);
        end
        n_cmp++;
        if (ready_bad !== 0 || mem_diff(base) !== 0) begin
            n_bad++;
            $display("FAIL throttle_ready: got %0d ready drops, %0d bad bytes required 0 0", ready_bad, mem_diff(base));
        end
    endtask

    task automatic test_reset_mid;
        fill_random(12);
        run_frame(14'h0123, 0, -1, 5);
        #1;
        n_cmp++;
        if ({bus.in_ready, busy, done, wrapped, byte_count, bus.onchip_memory2_0_s2_write,
             bus.onchip_memory2_0_s2_address, bus.onchip_memory2_0_s2_writedata, bus.onchip_memory2_0_s2_byteenable} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got busy %b count %0d write %b addr %h required all 0",
                     busy, byte_count, bus.onchip_memory2_0_s2_write, bus.onchip_memory2_0_s2_address);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (wq.size() !== 0) begin
            n_bad++;
            $display("FAIL midreset_nowrite: got %0d writes required 0", wq.size());
        end
        rst_n = 1;
        @(posedge clk); #1;
        fill_random(10);
        run_frame(14'h02A0, 0, -1, -1);
        n_cmp++;
        if (wq.size() !== 2 || wq[0].a !== 14'h02A0 || mem_diff(14'h02A0) !== 0 || byte_count !== 18'd10) begin
            n_bad++;
            $display("FAIL midreset_next: got %0d writes, %0d bad bytes, count %0d required 2 0 10",
                     wq.size(), mem_diff(14'h02A0), byte_count);
        end
    endtask

    task automatic test_start_ignored;
        fill_random(20);
        run_frame(14'h0500, 0, 3, -1);
        n_cmp++;
        if (wq.size() !== 3 || {wq[0].a, wq[1].a, wq[2].a} !== {14'h0500, 14'h0501, 14'h0502}) begin
            n_bad++;
            $display("FAIL start_ignored_addr: got %0d writes first %h required 3 from 0500", wq.size(), wq.size() ? wq[0].a : '0);
        end
        n_cmp++;
        if (mem_diff(14'h0500) !== 0 || byte_count !== 18'd20) begin
            n_bad++;
            $display("FAIL start_ignored_data: got %0d bad bytes count %0d required 0 20", mem_diff(14'h0500), byte_count);
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 8; f++) begin
            int n = $urandom_range(1, 40);
            logic [AW-1:0] base = $urandom_range(0, 1) ? 14'h3FFF - 14'($urandom_range(0, 5)) : 14'($urandom);
            bit thr = 1'($urandom_range(0, 1));
            int lat_bad = 0;
            fill_random(n);
            run_frame(base, thr, -1, -1);
            for (int w = 0; w < wq.size(); w++) begin
                int idx = (8 * w + 7 < n) ? 8 * w + 7 : n - 1;
                if (wq[w].cyc !== acc[idx] + 1) lat_bad++;
            end
            n_cmp++;
            if (mem_diff(base) !== 0 || wq.size() !== (n + 7) / 8) begin
                n_bad++;
                $display("FAIL rand_mem[%0d]: got %0d bad bytes %0d writes required 0 and %0d", f, mem_diff(base), wq.size(), (n + 7) / 8);
            end
            n_cmp++;
            if ({byte_count, wrapped} !== {18'(n), (int'(base) * 8 + n > MEMB)}) begin
                n_bad++;
                $display("FAIL rand_status[%0d]: got count %0d wrapped %b required %0d %b", f, byte_count, wrapped, n,
                         (int'(base) * 8 + n > MEMB));
            end
            n_cmp++;
            if (lat_bad !== 0 || done_cyc !== acc[n-1] + 2 || busy_after !== 0 || ready_bad !== 0) begin
                n_bad++;
                $display("FAIL rand_timing[%0d]: got lat_bad %0d done %0d busy_end %0d ready_drops %0d required 0 %0d 0 0",
                         f, lat_bad, done_cyc, busy_after, ready_bad, acc[n-1] + 2);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 0;
        bus.in_last  = 0;
        bus.in_data  = 0;
        test_reset();
        test_full_words();
        test_partial();
        test_wrap();
        test_throttle();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
